// File: rtl/ifetch.sv
// Instruction-fetch stage: owns the PC, keeps one request in flight on the
// instruction bus, and fills the IF/ID register. A one-entry skid buffer absorbs a fetch that returns during a decode stall.
module ifetch #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        decode_wait,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr
);

  typedef enum logic [1:0] {FETCH, BUF, DRAIN} state_e;

  state_e      state_q;
  logic [63:0] pc_q;
  logic [63:0] drain_addr_q;
  logic [63:0] skid_pc_q;
  logic [31:0] skid_instr_q;
  logic        accept;

  assign accept     = !out_valid || !decode_wait;
  assign ireq_valid = !reset && (state_q != BUF);
  // During DRAIN the bus still sees the abandoned address until its response arrives.
  assign ireq_addr  = (state_q == DRAIN) ? drain_addr_q : pc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      drain_addr_q <= '0;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
      out_valid    <= 1'b0;
      out_pc       <= '0;
      out_instr    <= '0;
    end else if (redirect_valid) begin
      out_valid    <= 1'b0;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
      pc_q         <= redirect_pc;
      case (state_q)
        FETCH: begin
          if (iresp_data_ok) begin
            state_q <= FETCH;
          end else begin
            drain_addr_q <= pc_q;
            state_q      <= DRAIN;
          end
        end
        BUF:     state_q <= FETCH;
        DRAIN:   state_q <= iresp_data_ok ? FETCH : DRAIN;
        default: state_q <= FETCH;
      endcase
    end else begin
      case (state_q)
        FETCH: begin
          if (iresp_data_ok) begin
            pc_q <= pc_q + 64'd4;
            if (accept) begin
              out_valid <= 1'b1;
              out_pc    <= pc_q;
              out_instr <= iresp_data;
            end else begin
              skid_pc_q    <= pc_q;
              skid_instr_q <= iresp_data;
              state_q      <= BUF;
            end
          end else if (accept) begin
            out_valid <= 1'b0;
          end
        end
        BUF: begin
          if (accept) begin
            out_valid <= 1'b1;
            out_pc    <= skid_pc_q;
            out_instr <= skid_instr_q;
            state_q   <= FETCH;
          end
        end
        DRAIN: begin
          if (iresp_data_ok) state_q <= FETCH;
        end
        default: state_q <= FETCH;
      endcase
    end
  end

endmodule

// File: doc/ifetch.md
# ifetch

Instruction-fetch stage of the five-stage pipeline, directly upstream of decode and of the forwarding/hazard unit. It owns the PC and issues single-outstanding requests on the instruction bus. Fetched instructions go into the IF/ID output register. The register holds while decode signals `decode_wait`, and branch redirects from execute flush it.

## Interface
Parameters:
- `RESET_PC`, default 64'h8000_0000, PC loaded on reset.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `ireq_valid`  out  1  instruction request valid.
- `ireq_addr`  out  64  request address, which is the fetch PC.
- `iresp_data_ok`  in  1  response for the outstanding request is complete this cycle.
- `iresp_data`  in  32  instruction word, valid when `iresp_data_ok`=1.
- `decode_wait`  in  1  decode stall from the forwarding unit; holds the IF/ID register.
- `redirect_valid`  in  1  branch/jump taken in execute; flush and refetch.
- `redirect_pc`  in  64  redirect target, used as-is.
- `out_valid`  out  1  IF/ID register holds a valid instruction.
- `out_pc`  out  64  PC of `out_instr`.
- `out_instr`  out  32  instruction word.

## Operation
Architectural state:
- `pc`.
- State register: FETCH, BUF or DRAIN.
- One-entry skid buffer: `skid_pc`, `skid_instr`.
- IF/ID register: `out_*`.

Bus rules:
- `ireq_valid` = 1 in FETCH and DRAIN, 0 in BUF and while `reset`=1.
- `ireq_addr` = `pc` in FETCH, and the latched in-flight address in DRAIN.
- Address is stable while `ireq_valid`=1 and `iresp_data_ok`=0.
- At most one request outstanding.

Terms used below:
- "Accept" = (`out_valid`=0 or `decode_wait`=0).
- "Hold" = `out_valid`=1 and `decode_wait`=1.

FETCH, `iresp_data_ok`=1, no redirect:
- `pc` <= `pc`+4 (64-bit, wraps modulo 2^64).
- If accept: `out_*` <= {1, `pc`, `iresp_data`}; stay in FETCH.
- If hold: skid <= {`pc`, `iresp_data`}; go to BUF.

FETCH, `iresp_data_ok`=0:
- If accept, `out_valid` <= 0 (bubble).
- If hold, `out_*` is unchanged.

BUF:
- If accept: `out_*` <= {1, `skid_pc`, `skid_instr`}; go to FETCH.
- Otherwise stay in BUF.

DRAIN:
- Wait for `iresp_data_ok`, discard the data, go to FETCH.
- `out_valid` stays 0.

Redirect (`redirect_valid`=1) has highest priority, overriding `decode_wait` and any `iresp_data_ok` data:
- `out_valid` <= 0; skid is invalidated; `pc` <= `redirect_pc`.
- In FETCH with `iresp_data_ok`=0, the request is in flight: latch the in-flight address, go to DRAIN.
- In FETCH with `iresp_data_ok`=1, or in BUF: go to FETCH; the response is discarded.
- In DRAIN: update `pc`, stay in DRAIN (or go to FETCH if `iresp_data_ok`=1 the same cycle).

Reset:
- `pc` <= `RESET_PC`; state <= FETCH.
- `out_valid` <= 0; `out_pc` <= 0; `out_instr` <= 0; skid cleared.
- Reset mid-request abandons the in-flight transaction. The memory side is reset by the same signal, so no drain is needed.

## Timing
- Reset values of all outputs:
  - `ireq_valid`=0 during the reset cycle, then 1.
  - `ireq_addr`=`RESET_PC`.
  - `out_valid`=0, `out_pc`=0, `out_instr`=0.
- `iresp_data_ok` may assert in the same cycle `ireq_valid` first rises (zero-wait memory).
- Instruction latency: visible on `out_*` the cycle after `iresp_data_ok`.
- With zero-wait memory and no stalls, throughput is one instruction per cycle.
- The request for `pc`+4 issues in the cycle after the previous `iresp_data_ok`. `ireq_valid` stays 1 across back-to-back fetches.
- Redirect: the first request to `redirect_pc` issues the cycle after the redirect, or the cycle after the drained `iresp_data_ok` if in flight.
- Redirected PCs never appear on `out_*` with a stale instruction.
- `decode_wait` is sampled combinationally each cycle. No output depends combinationally on `decode_wait` or `redirect_valid`; all outputs are registered or state-derived.

## Test plan
- **Reset:**
  - Stimulus: `reset`=1 for 2 cycles, then 0; memory returns `iresp_data_ok`=1 immediately with data 32'h0000_0013.
  - Response: `ireq_valid`=0 during reset. Then `ireq_addr`=8000_0000, 8000_0004, …. Then `out_valid`=1 with `out_pc`=8000_0000 one cycle after the first `data_ok`.
- **Streaming:**
  - Stimulus: 3-cycle memory latency.
  - Response: `out_pc` steps 8000_0000, 8000_0004, 8000_0008. Each instruction is valid for one cycle, followed by 3 bubble cycles. `ireq_addr` is stable while waiting.
- **Stall/skid:**
  - Stimulus: `decode_wait`=1 for 4 cycles while `out_pc`=8000_0004 and `data_ok` returns 8000_0008.
  - Response: `out_*` held. State BUF with `ireq_valid`=0. On release, `out_pc`=8000_0008 the next cycle, and the request for 8000_000C follows.
- **Redirect in flight:**
  - Stimulus: `redirect_valid`=1, `redirect_pc`=8000_0100 while the request for 8000_0010 is pending for 2 more cycles.
  - Response: `out_valid`=0. `ireq_addr` stays 8000_0010 until `data_ok`, and that data is discarded. Next request is 8000_0100, and `out_pc`=8000_0100 afterward.
- **Coincident redirect:**
  - Stimulus: `redirect_valid` and `iresp_data_ok` in the same cycle, with `decode_wait`=1.
  - Response: the data is dropped, `out_valid`=0, and the next `ireq_addr` = `redirect_pc`.
- **Reset mid-stall:**
  - Stimulus: assert `reset` while in BUF.
  - Response: `out_valid`=0, skid cleared, `ireq_addr`=`RESET_PC` after release.
